// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, RV32I opcodes and datapath select encodings for mc_control_fsm.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_RST, S_IF, S_ID, S_EX_R, S_EX_I, S_EX_ADR, S_MEM_RD, S_MEM_WR,
        S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JAL, S_EX_JALR, S_HALT
    } state_t;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_RF = 2'b10, ALU_IF = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01;
    localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] A_PC = 2'b00, A_REG = 2'b01, A_OLDPC = 2'b10;
    localparam logic [1:0] B_REG = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       is_halted;
    } ctrl_t;
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction-register/memory inputs and datapath controls of the multicycle control unit.
interface mc_control_fsm_if #(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W = 2
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]          pc_source, mem_to_reg, alu_src_a, alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic                is_halted, err_illegal, err_timeout;
    logic [3:0]          state_o;
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted,
               err_illegal, err_timeout, state_o
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted,
               err_illegal, err_timeout, state_o
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-control decoder (Moore outputs of the control FSM).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctl
);
    always_comb begin
        ctl = '0;
        unique case (state)
            S_IF: begin
                ctl.mem_read  = 1'b1;
                ctl.ir_write  = 1'b1;
                ctl.pc_write  = 1'b1;
                ctl.alu_src_a = A_PC;
                ctl.alu_src_b = B_FOUR;
                ctl.pc_source = PC_ALU;
            end
            S_ID: begin
                ctl.alu_src_a = A_OLDPC;
                ctl.alu_src_b = B_IMM;
                ctl.alu_op    = ALU_ADD;
            end
            S_EX_R: begin
                ctl.alu_src_a = A_REG;
                ctl.alu_src_b = B_REG;
                ctl.alu_op    = ALU_RF;
            end
            S_EX_I: begin
                ctl.alu_src_a = A_REG;
                ctl.alu_src_b = B_IMM;
                ctl.alu_op    = ALU_IF;
            end
            S_EX_ADR: begin
                ctl.alu_src_a = A_REG;
                ctl.alu_src_b = B_IMM;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_WB_ALU: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_ALUOUT;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_MDR;
            end
            S_EX_BR: begin
                ctl.alu_src_a     = A_REG;
                ctl.alu_src_b     = B_REG;
                ctl.alu_op        = ALU_BR;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PC_ALUOUT;
            end
            S_EX_JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PC_ALUOUT;
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_PC;
            end
            S_EX_JALR: begin
                ctl.alu_src_a  = A_REG;
                ctl.alu_src_b  = B_IMM;
                ctl.pc_write   = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = M2R_PC;
            end
            S_HALT: ctl.is_halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control FSM driving datapath enables/selects from its state.
// Define MEM_WAIT_EN to hold IF/MEM_RD/MEM_WR until mem_ready, with a WAIT_MAX stall timeout.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int                  OPCODE_W    = 7,
    parameter int                  ALUOP_W     = 2,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OPCODE_W'(OP_ECALL),
    parameter int                  WAIT_MAX    = 15
) (
    input logic              clk,
    input logic              reset,
    mc_control_fsm_if.master bus
);
    state_t              state_q, state_d;
    logic                is_load_q, is_load_d, err_illegal_q, err_illegal_d;
    logic                mem_done, expired, if_gate;
    logic [OPCODE_W-1:0] op;
    ctrl_t               ctl;
    assign op = bus.opcode;
`ifdef MEM_WAIT_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_timeout_q, err_timeout_d, mem_st;
    assign mem_st   = state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_WR;
    assign mem_done = bus.mem_ready;
    // ready on the last allowed cycle still completes the access
    assign expired  = mem_st && !bus.mem_ready && wait_q == WAIT_W'(WAIT_MAX);
    assign if_gate  = state_q != S_IF || bus.mem_ready;
    assign bus.err_timeout = err_timeout_q;
`else
    assign mem_done = 1'b1;
    assign expired  = 1'b0;
    assign if_gate  = 1'b1;
    assign bus.err_timeout = 1'b0;
`endif
    always_comb begin
        state_d       = state_q;
        is_load_d     = is_load_q;
        err_illegal_d = err_illegal_q;
        unique case (state_q)
            S_RST:    state_d = S_IF;
            S_IF:     state_d = mem_done ? S_ID : expired ? S_HALT : state_q;
            S_ID: begin
                is_load_d     = op == OPCODE_W'(OP_LOAD);
                state_d       = op == OPCODE_W'(OP_R) ? S_EX_R :
                                op == OPCODE_W'(OP_I) ? S_EX_I :
                                (op == OPCODE_W'(OP_LOAD) || op == OPCODE_W'(OP_STORE)) ? S_EX_ADR :
                                op == OPCODE_W'(OP_BRANCH) ? S_EX_BR :
                                op == OPCODE_W'(OP_JAL) ? S_EX_JAL :
                                op == OPCODE_W'(OP_JALR) ? S_EX_JALR : S_HALT;
                err_illegal_d = err_illegal_q | (state_d == S_HALT && op != HALT_OPCODE);
            end
            S_EX_R, S_EX_I: state_d = S_WB_ALU;
            S_EX_ADR: state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = mem_done ? S_WB_MEM : expired ? S_HALT : state_q;
            S_MEM_WR: state_d = mem_done ? S_IF : expired ? S_HALT : state_q;
            S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JAL, S_EX_JALR: state_d = S_IF;
            default:  state_d = S_HALT;
        endcase
    end
`ifdef MEM_WAIT_EN
    always_comb begin
        wait_d        = (state_d != state_q || !mem_st) ? '0 : wait_q + 1'b1;
        err_timeout_d = err_timeout_q | expired;
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RST;
            is_load_q     <= 1'b0;
            err_illegal_q <= 1'b0;
`ifdef MEM_WAIT_EN
            wait_q        <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            is_load_q     <= is_load_d;
            err_illegal_q <= err_illegal_d;
`ifdef MEM_WAIT_EN
            wait_q        <= wait_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end
    mc_ctrl_decode u_decode (.state(state_q), .ctl(ctl));
    assign bus.pc_write      = ctl.pc_write & if_gate;
    assign bus.ir_write      = ctl.ir_write & if_gate;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.i_or_d        = ctl.i_or_d;
    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.reg_write     = ctl.reg_write;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.alu_op        = ALUOP_W'(ctl.alu_op);
    assign bus.is_halted     = ctl.is_halted;
    assign bus.err_illegal   = err_illegal_q;
    assign bus.state_o       = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scoreboard bench; expected per-cycle state/controls queued, then checked each cycle.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;
    typedef struct packed {
        logic       pcw, pcwc;
        logic [1:0] pcs;
        logic       iord, mr, mw, irw;
        logic [1:0] m2r;
        logic       rw;
        logic [1:0] a, b, op;
        logic       halt, ill, to;
    } exp_ctl_t;
    typedef struct packed {
        state_t   st;
        exp_ctl_t c;
    } exp_t;
    logic     clk = 1'b0;
    logic     reset;
    int       n_assert = 0, n_fail = 0;
    logic     exp_ill = 1'b0, exp_to = 1'b0;
    exp_t     sb[$];
    exp_ctl_t obs;
    mc_control_fsm_if #(.OPCODE_W(7), .ALUOP_W(2)) bus ();
    mc_control_fsm #(.WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.is_halted, bus.err_illegal, bus.err_timeout};
    always #5 clk = ~clk;
    function automatic exp_ctl_t model(state_t s, logic rdy);
        exp_ctl_t c = '0;
        case (s)
            S_IF:      begin c.mr = 1; c.irw = rdy; c.pcw = rdy; c.b = 2'b01; end
            S_ID:      begin c.a = 2'b10; c.b = 2'b10; end
            S_EX_R:    begin c.a = 2'b01; c.op = 2'b10; end
            S_EX_I:    begin c.a = 2'b01; c.b = 2'b10; c.op = 2'b11; end
            S_EX_ADR:  begin c.a = 2'b01; c.b = 2'b10; end
            S_MEM_RD:  begin c.mr = 1; c.iord = 1; end
            S_MEM_WR:  begin c.mw = 1; c.iord = 1; end
            S_WB_ALU:  c.rw = 1;
            S_WB_MEM:  begin c.rw = 1; c.m2r = 2'b01; end
            S_EX_BR:   begin c.a = 2'b01; c.op = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
            S_EX_JAL:  begin c.pcw = 1; c.pcs = 2'b01; c.rw = 1; c.m2r = 2'b10; end
            S_EX_JALR: begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1; c.rw = 1; c.m2r = 2'b10; end
            S_HALT:    c.halt = 1;
            default:   ;
        endcase
        c.ill = exp_ill;
        c.to  = exp_to;
        return c;
    endfunction
    task automatic push(state_t s, logic rdy = 1'b1);
        exp_t e;
        e.st = s;
        e.c  = model(s, rdy);
        sb.push_back(e);
    endtask
    task automatic check(string tag);
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard empty observed_state=%0d", tag, bus.state_o);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        n_assert++;
        assert (bus.state_o === e.st) else begin
            n_fail++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state_o, e.st);
        end
        n_assert++;
        assert (obs === e.c) else begin
            n_fail++;
            $error("FAIL %s controls (state %0d) observed=%b expected=%b", tag, e.st, obs, e.c);
        end
    endtask
    task automatic step(string tag);
        @(negedge clk);
        check(tag);
    endtask
    task automatic do_reset();
        #2 reset = 1'b1;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        #1 push(S_RST);
        check("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic instr(string tag, logic [6:0] op, state_t seq [5], int n);
        bus.opcode = op;
        for (int i = 0; i < n; i++) push(seq[i]);
        for (int i = 0; i < n; i++) step(tag);
    endtask
    initial begin
        #100000;
        $error("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b0;
        bus.opcode = '0;
        bus.mem_ready = 1'b1;
        do_reset();
        instr("add",  OP_R,      '{S_IF, S_ID, S_EX_R,    S_WB_ALU, S_RST},    4);
        instr("addi", OP_I,      '{S_IF, S_ID, S_EX_I,    S_WB_ALU, S_RST},    4);
        instr("lw",   OP_LOAD,   '{S_IF, S_ID, S_EX_ADR,  S_MEM_RD, S_WB_MEM}, 5);
        instr("sw",   OP_STORE,  '{S_IF, S_ID, S_EX_ADR,  S_MEM_WR, S_RST},    4);
        instr("beq",  OP_BRANCH, '{S_IF, S_ID, S_EX_BR,   S_RST,    S_RST},    3);
        instr("jal",  OP_JAL,    '{S_IF, S_ID, S_EX_JAL,  S_RST,    S_RST},    3);
        instr("jalr", OP_JALR,   '{S_IF, S_ID, S_EX_JALR, S_RST,    S_RST},    3);
        instr("lw_cut", OP_LOAD, '{S_IF, S_ID, S_EX_ADR,  S_MEM_RD, S_RST},    4);
        do_reset();
        instr("add_restart", OP_R, '{S_IF, S_ID, S_EX_R, S_WB_ALU, S_RST}, 4);
        instr("ecall", 7'b1110011, '{S_IF, S_ID, S_HALT, S_RST, S_RST}, 3);
        bus.opcode = OP_R;
        for (int i = 0; i < 100; i++) push(S_HALT);
        for (int i = 0; i < 100; i++) step("halt_hold");
        do_reset();
        bus.opcode = 7'b1111111;
        push(S_IF);
        push(S_ID);
        exp_ill = 1'b1;
        push(S_HALT);
        push(S_HALT);
        for (int i = 0; i < 4; i++) step("illegal");
        do_reset();
        instr("add_clean", OP_R, '{S_IF, S_ID, S_EX_R, S_WB_ALU, S_RST}, 4);
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b0;
        bus.opcode = OP_R;
        for (int i = 0; i < 3; i++) push(S_IF, 1'b0);
        for (int i = 0; i < 3; i++) step("if_stall");
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        push(S_IF);
        push(S_ID);
        push(S_EX_R);
        push(S_WB_ALU);
        for (int i = 0; i < 4; i++) step("if_release");
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(S_IF, 1'b0);
        exp_to = 1'b1;
        push(S_HALT);
        for (int i = 0; i < 17; i++) step("timeout");
        bus.mem_ready = 1'b1;
        do_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
